// File: rtl/mips_seq_alu_if.sv
// Handshake and result bus of the sequential MIPS ALU.
// The slave side is the ALU; the master side is the decode/writeback stage.
interface mips_seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             co;
    logic             ovr;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, co, ovr, zero, hi, lo
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, co, ovr, zero, hi, lo
    );
endinterface

// File: rtl/mips_seq_alu.sv
// Registered MIPS ALU: single-cycle logic/arith/compare ops, and iterative
// MULTU (shift-add) / DIVU (restoring) into HI/LO over WIDTH cycles.
module mips_seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_seq_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_MULT = 3'b110;
    localparam logic [2:0] OP_DIVU = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_acc;     // MUL: running high product; DIV: partial remainder
    logic [WIDTH-1:0] r_mq;      // MUL: multiplier/low product; DIV: dividend/quotient
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result, r_hi, r_lo;
    logic             r_co, r_ovr, r_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_sub;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;
    logic             w_add_ovr;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_co, w_alu_ovr;

    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_dshift;
    logic             w_dge;
    logic [WIDTH-1:0] w_ddiff;
    logic [WIDTH-1:0] w_it_acc, w_it_mq;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // SUB reuses the adder as a + ~b + 1, so carry-out means a >= b
    assign w_sub     = (bus.op == OP_SUB);
    assign w_bx      = w_sub ? ~bus.b : bus.b;
    assign w_sum     = {1'b0, bus.a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
    assign w_add_ovr = (bus.a[WIDTH-1] == w_bx[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != bus.a[WIDTH-1]);

    always_comb begin
        w_alu_res = '0;
        w_alu_co  = 1'b0;
        w_alu_ovr = 1'b0;
        case (bus.op)
            OP_AND:         w_alu_res = bus.a & bus.b;
            OP_OR:          w_alu_res = bus.a | bus.b;
            OP_ADD, OP_SUB: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_co  = w_sum[WIDTH];
                w_alu_ovr = w_add_ovr;
            end
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: w_alu_res = '0;
        endcase
    end

    // Shift-add step: conditional add of the multiplicand, then shift {acc,mq} right
    assign w_madd = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

    // Restoring step; with b==0 every step subtracts nothing, giving q=all ones, rem=a
    assign w_dshift = {r_acc, r_mq[WIDTH-1]};
    assign w_dge    = (w_dshift >= {1'b0, r_b});
    assign w_ddiff  = w_dshift[WIDTH-1:0] - r_b;

    always_comb begin
        if (r_state == S_MUL) begin
            w_it_acc = w_madd[WIDTH:1];
            w_it_mq  = {w_madd[0], r_mq[WIDTH-1:1]};
        end else begin
            w_it_acc = w_dge ? w_ddiff : w_dshift[WIDTH-1:0];
            w_it_mq  = {r_mq[WIDTH-2:0], w_dge};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (bus.op == OP_MULT)      w_next = S_MUL;
                else if (bus.op == OP_DIVU) w_next = S_DIV;
                else                        w_next = S_DONE;
            end
            S_MUL, S_DIV: if (w_last) w_next = S_DONE;
            S_DONE:       if (bus.out_ready) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_IDLE) && rst_n;
        bus.out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mq     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_co     <= 1'b0;
            r_ovr    <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_acc <= '0;
                    r_mq  <= bus.a;
                    r_b   <= bus.b;
                    r_cnt <= '0;
                    if (bus.op[2:1] != 2'b11) begin
                        r_result <= w_alu_res;
                        r_co     <= w_alu_co;
                        r_ovr    <= w_alu_ovr;
                        r_zero   <= (w_alu_res == '0);
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= w_it_acc;
                    r_mq  <= w_it_mq;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_hi     <= w_it_acc;
                        r_lo     <= w_it_mq;
                        r_result <= w_it_mq;
                        r_co     <= 1'b0;
                        r_ovr    <= 1'b0;
                        r_zero   <= (w_it_mq == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.co     = r_co;
    assign bus.ovr    = r_ovr;
    assign bus.zero   = r_zero;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;
endmodule
